// File: rtl/pwm_duty_sequencer.sv
// ============================================================================
// pwm_duty_sequencer
// ----------------------------------------------------------------------------
// Sequences per-channel duty updates into the motor PWM datapath. It accepts
// duty commands over a valid/ready handshake, enforces an arming sequence,
// slew-limits every channel once per PWM period and ramps all channels down
// to zero when the command source goes quiet for too long.
//
// Parameters
//   NUM_CH        number of motor channels
//   DUTY_W        duty value width (unsigned)
//   STEP          largest per-channel duty change in one PWM period
//   ARM_PERIODS   PWM periods spent in ARMING before ARMED
//   WDOG_PERIODS  consecutive PWM periods without a command before FAILSAFE
//
// Ports
//   clk           system clock, rising edge
//   resetn        asynchronous active-low reset
//   arm_req       level, 1 requests armed operation
//   period_start  one-cycle pulse at the start of every PWM period
//   cmd_valid     command valid
//   cmd_ready     command ready (only while ARMED)
//   cmd_ch        target channel of the command
//   cmd_duty      target duty of the command
//   duty_out      channel i at [i*DUTY_W +: DUTY_W]
//   duty_load     one-cycle pulse alongside every duty_out update
//   state         0 DISARMED, 1 ARMING, 2 ARMED, 3 FAILSAFE
//   armed         high while ARMED
// ============================================================================
module pwm_duty_sequencer #(
   parameter int NUM_CH       = 4,
   parameter int DUTY_W       = 10,
   parameter int STEP         = 8,
   parameter int ARM_PERIODS  = 4,
   parameter int WDOG_PERIODS = 50
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       arm_req,
   input  logic                       period_start,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [$clog2(NUM_CH)-1:0]  cmd_ch,
   input  logic [DUTY_W-1:0]          cmd_duty,
   output logic [NUM_CH*DUTY_W-1:0]   duty_out,
   output logic                       duty_load,
   output logic [1:0]                 state,
   output logic                       armed
);

   localparam int CH_W       = $clog2(NUM_CH);
   localparam int ARM_CNT_W  = $clog2(ARM_PERIODS + 1);
   localparam int WDOG_CNT_W = $clog2(WDOG_PERIODS + 1);

   localparam logic [DUTY_W-1:0]     STEP_D    = DUTY_W'(STEP);
   localparam logic [ARM_CNT_W-1:0]  ARM_LAST  = ARM_CNT_W'(ARM_PERIODS - 1);
   localparam logic [WDOG_CNT_W-1:0] WDOG_LAST = WDOG_CNT_W'(WDOG_PERIODS - 1);

   typedef enum logic [1:0] {
      ST_DISARMED = 2'd0,
      ST_ARMING   = 2'd1,
      ST_ARMED    = 2'd2,
      ST_FAILSAFE = 2'd3
   } state_t;

   // -------------------------------------------------------------------------
   // Slew limiter: move d toward t by at most STEP, landing exactly on t.
   // Differences are taken in the direction that cannot wrap, so there is no
   // overflow or underflow for any d/t pair.
   // -------------------------------------------------------------------------
   function automatic logic [DUTY_W-1:0] f_slew(
      input logic [DUTY_W-1:0] d,
      input logic [DUTY_W-1:0] t
   );
      logic [DUTY_W-1:0] diff;
      diff   = '0;
      f_slew = d;
      if (d < t) begin
         diff   = t - d;
         f_slew = (diff > STEP_D) ? (d + STEP_D) : t;
      end else if (d > t) begin
         diff   = d - t;
         f_slew = (diff > STEP_D) ? (d - STEP_D) : t;
      end
   endfunction

   // -------------------------------------------------------------------------
   // Registers and wires
   // -------------------------------------------------------------------------
   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ARM_CNT_W-1:0]    r_arm_cnt;
   logic [WDOG_CNT_W-1:0]   r_wdog_cnt;
   logic [DUTY_W-1:0]       r_tgt  [NUM_CH];
   logic [DUTY_W-1:0]       r_duty [NUM_CH];
   logic                    r_duty_load;

   logic                    w_xfer;
   logic                    w_force_zero;
   logic                    w_clr_tgt;
   logic [DUTY_W-1:0]       w_duty_nxt [NUM_CH];
   logic [NUM_CH*DUTY_W-1:0] w_duty_flat;

   // Ready depends only on the state so the command source never sees a
   // combinational path from its own valid back to ready.
   assign cmd_ready = (r_state == ST_ARMED);
   assign w_xfer    = cmd_valid & cmd_ready;
   assign state     = r_state;
   assign armed     = (r_state == ST_ARMED);
   assign duty_load = r_duty_load;
   assign duty_out  = w_duty_flat;

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_DISARMED;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and side-effect strobes. Dropping arm_req is checked
   // first in every state so it beats any other event in the same cycle.
   // In ARMED, an accepted command in the expiry cycle keeps the block armed.
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_force_zero = 1'b0;
      w_clr_tgt    = 1'b0;
      case (r_state)
         ST_DISARMED: begin
            if (arm_req) begin
               w_state_nxt = ST_ARMING;
            end
         end
         ST_ARMING: begin
            if (!arm_req) begin
               w_state_nxt = ST_DISARMED;
            end else if (period_start && (r_arm_cnt == ARM_LAST)) begin
               w_state_nxt = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (!arm_req) begin
               w_state_nxt  = ST_DISARMED;
               w_force_zero = 1'b1;
               w_clr_tgt    = 1'b1;
            end else if (period_start && !w_xfer && (r_wdog_cnt == WDOG_LAST)) begin
               w_state_nxt = ST_FAILSAFE;
               w_clr_tgt   = 1'b1;
            end
         end
         ST_FAILSAFE: begin
            if (!arm_req) begin
               w_state_nxt  = ST_DISARMED;
               w_force_zero = 1'b1;
               w_clr_tgt    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_DISARMED;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Arm counter: counts period pulses while ARMING, zero everywhere else.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_arm_cnt <= '0;
      end else if (w_state_nxt != ST_ARMING) begin
         r_arm_cnt <= '0;
      end else if (period_start && (r_state == ST_ARMING)) begin
         r_arm_cnt <= r_arm_cnt + 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Watchdog counter: counts periods without an accepted command. The
   // r_state check keeps the final arming pulse from being counted.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wdog_cnt <= '0;
      end else if ((w_state_nxt != ST_ARMED) || w_xfer) begin
         r_wdog_cnt <= '0;
      end else if (period_start && (r_state == ST_ARMED)) begin
         r_wdog_cnt <= r_wdog_cnt + 1'b1;
      end
   end

   // -------------------------------------------------------------------------
   // Target registers written by the handshake, cleared on disarm/failsafe.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_tgt[i] <= '0;
         end
      end else if (w_clr_tgt) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_tgt[i] <= '0;
         end
      end else if (w_xfer) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cmd_ch == CH_W'(i)) begin
               r_tgt[i] <= cmd_duty;
            end
         end
      end
   end

   // -------------------------------------------------------------------------
   // Slewed duty candidates. Targets are only honoured while ARMED; in every
   // other state the channels head for zero. The targets read here are the
   // registered ones, so a command accepted on a period edge waits a period.
   // -------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         w_duty_nxt[i] = f_slew(r_duty[i], (r_state == ST_ARMED) ? r_tgt[i] : '0);
      end
   end

   // -------------------------------------------------------------------------
   // Duty registers and load strobe. A disarm from ARMED or FAILSAFE is a
   // hard cut to zero, loaded immediately without waiting for a period.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_duty[i] <= '0;
         end
         r_duty_load <= 1'b0;
      end else if (w_force_zero) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_duty[i] <= '0;
         end
         r_duty_load <= 1'b1;
      end else if (period_start) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_duty[i] <= w_duty_nxt[i];
         end
         r_duty_load <= 1'b1;
      end else begin
         r_duty_load <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Pack channels onto the output bus.
   // -------------------------------------------------------------------------
   always_comb begin
      w_duty_flat = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_duty_flat[i*DUTY_W +: DUTY_W] = r_duty[i];
      end
   end

endmodule
